// File: rtl/fetch_sequencer_if.sv
// Control-plane bundle between the fetch sequencer and the 8-bit CPU datapath.
// The master is the sequencer: it takes opcode/flags/run and drives every bus strobe.
interface fetch_sequencer_if;
  logic       run;
  logic [3:0] opcode;
  logic       carry_flag;
  logic       zero_flag;

  logic       pc_ep;
  logic       pc_cp;
  logic       pc_lp;
  logic       mar_lm;
  logic       ram_ce;
  logic       ram_ri;
  logic       ir_li;
  logic       ir_ei;
  logic       a_la;
  logic       a_ea;
  logic       b_lb;
  logic       alu_eu;
  logic       alu_su;
  logic       flags_lf;
  logic       out_lo;
  logic       halted;
  logic [2:0] t_state;

  modport master (
    input  run, opcode, carry_flag, zero_flag,
    output pc_ep, pc_cp, pc_lp, mar_lm, ram_ce, ram_ri, ir_li, ir_ei,
           a_la, a_ea, b_lb, alu_eu, alu_su, flags_lf, out_lo, halted, t_state
  );

  modport slave (
    output run, opcode, carry_flag, zero_flag,
    input  pc_ep, pc_cp, pc_lp, mar_lm, ram_ce, ram_ri, ir_li, ir_ei,
           a_la, a_ea, b_lb, alu_eu, alu_su, flags_lf, out_lo, halted, t_state
  );
endinterface

// File: rtl/fetch_sequencer.sv
// T-state sequencer for the 8-bit CPU: a 3-bit state register plus a purely
// combinational decode of (state, opcode, flags) into every datapath strobe.
module fetch_sequencer #(
  parameter int STEPS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef struct packed {
    logic pc_ep;
    logic pc_cp;
    logic pc_lp;
    logic mar_lm;
    logic ram_ce;
    logic ram_ri;
    logic ir_li;
    logic ir_ei;
    logic a_la;
    logic a_ea;
    logic b_lb;
    logic alu_eu;
    logic alu_su;
    logic flags_lf;
    logic out_lo;
  } strobes_t;

  // The last execute step is the only one that samples run again.
  localparam state_t LAST_T = state_t'(STEPS[2:0]);

  state_t   state;
  state_t   state_next;
  strobes_t s;

  // NOTE: state is the only storage; non-blocking assignment keeps every reader
  // of 'state' seeing the pre-edge value regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (bus.run) state_next = S_T1;
      S_HALT:  state_next = S_HALT;
      S_T4:    state_next = (bus.opcode == OP_HLT) ? S_HALT : S_T5;
      LAST_T:  state_next = bus.run ? S_T1 : S_IDLE;
      default: state_next = state_t'(state + 3'd1);
    endcase
  end

  // NOTE: every strobe is cleared before the case so no path through the
  // decode leaves an output unassigned and infers a latch.
  always_comb begin
    s = '0;
    unique case (state)
      S_T1: begin
        s.pc_ep  = 1'b1;
        s.mar_lm = 1'b1;
      end
      S_T2: s.pc_cp = 1'b1;
      S_T3: begin
        s.ram_ce = 1'b1;
        s.ir_li  = 1'b1;
      end
      S_T4: begin
        case (bus.opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            s.ir_ei  = 1'b1;
            s.mar_lm = 1'b1;
          end
          OP_LDI: begin
            s.ir_ei = 1'b1;
            s.a_la  = 1'b1;
          end
          OP_JMP: begin
            s.ir_ei = 1'b1;
            s.pc_lp = 1'b1;
          end
          // Conditional jumps follow the live flag within this cycle.
          OP_JC: begin
            s.ir_ei = bus.carry_flag;
            s.pc_lp = bus.carry_flag;
          end
          OP_JZ: begin
            s.ir_ei = bus.zero_flag;
            s.pc_lp = bus.zero_flag;
          end
          OP_OUT: begin
            s.a_ea   = 1'b1;
            s.out_lo = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (bus.opcode)
          OP_LDA: begin
            s.ram_ce = 1'b1;
            s.a_la   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            s.ram_ce = 1'b1;
            s.b_lb   = 1'b1;
          end
          OP_STA: begin
            s.a_ea   = 1'b1;
            s.ram_ri = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
          s.alu_eu   = 1'b1;
          s.a_la     = 1'b1;
          s.flags_lf = 1'b1;
          s.alu_su   = (bus.opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

  assign bus.pc_ep    = s.pc_ep;
  assign bus.pc_cp    = s.pc_cp;
  assign bus.pc_lp    = s.pc_lp;
  assign bus.mar_lm   = s.mar_lm;
  assign bus.ram_ce   = s.ram_ce;
  assign bus.ram_ri   = s.ram_ri;
  assign bus.ir_li    = s.ir_li;
  assign bus.ir_ei    = s.ir_ei;
  assign bus.a_la     = s.a_la;
  assign bus.a_ea     = s.a_ea;
  assign bus.b_lb     = s.b_lb;
  assign bus.alu_eu   = s.alu_eu;
  assign bus.alu_su   = s.alu_su;
  assign bus.flags_lf = s.flags_lf;
  assign bus.out_lo   = s.out_lo;
  assign bus.halted   = (state == S_HALT);
  assign bus.t_state  = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized
// run compared against a microcode-table model of the instruction set.
module tb_fetch_sequencer;

  localparam logic [14:0] EP = 15'h4000, CP = 15'h2000, LP = 15'h1000, LM = 15'h0800;
  localparam logic [14:0] CE = 15'h0400, RI = 15'h0200, LI = 15'h0100, EI = 15'h0080;
  localparam logic [14:0] LA = 15'h0040, EA = 15'h0020, LB = 15'h0010, EU = 15'h0008;
  localparam logic [14:0] SU = 15'h0004, LF = 15'h0002, LO = 15'h0001;
  localparam logic [14:0] DRIVERS = EP | CE | EI | EA | EU;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;
  int   ms = 0;                    // model step: 0 idle, 1..6 T-states, 7 halt
  logic [14:0] ucode [16][7];
  logic [14:0] dut_s;

  fetch_sequencer_if bus();

  fetch_sequencer #(.STEPS(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign dut_s = {bus.pc_ep, bus.pc_cp, bus.pc_lp, bus.mar_lm, bus.ram_ce, bus.ram_ri,
                  bus.ir_li, bus.ir_ei, bus.a_la, bus.a_ea, bus.b_lb, bus.alu_eu,
                  bus.alu_su, bus.flags_lf, bus.out_lo};

  task automatic init_ucode();
    for (int op = 0; op < 16; op++) begin
      for (int t = 0; t < 7; t++) ucode[op][t] = '0;
      ucode[op][1] = EP | LM;
      ucode[op][2] = CP;
      ucode[op][3] = CE | LI;
    end
    ucode[1][4]  = EI | LM;  ucode[1][5] = CE | LA;
    ucode[2][4]  = EI | LM;  ucode[2][5] = CE | LB;  ucode[2][6] = EU | LA | LF;
    ucode[3][4]  = EI | LM;  ucode[3][5] = CE | LB;  ucode[3][6] = EU | LA | LF | SU;
    ucode[4][4]  = EI | LM;  ucode[4][5] = EA | RI;
    ucode[5][4]  = EI | LA;
    ucode[6][4]  = EI | LP;
    ucode[7][4]  = EI | LP;
    ucode[8][4]  = EI | LP;
    ucode[14][4] = EA | LO;
  endtask

  function automatic logic [14:0] model_s();
    logic [14:0] w;
    if (ms < 1 || ms > 6) return '0;
    w = ucode[bus.opcode][ms];
    if (ms == 4 && ((bus.opcode == 4'h7 && !bus.carry_flag) ||
                    (bus.opcode == 4'h8 && !bus.zero_flag)))
      w = '0;
    return w;
  endfunction

  // Advance one clock; the model consumes the inputs held across the edge.
  task automatic tick();
    int nxt;
    case (ms)
      0:       nxt = bus.run ? 1 : 0;
      4:       nxt = (bus.opcode == 4'hF) ? 7 : 5;
      6:       nxt = bus.run ? 1 : 0;
      7:       nxt = 7;
      default: nxt = ms + 1;
    endcase
    @(posedge clk);
    #1;
    ms = nxt;
  endtask

  task automatic go_idle();
    bus.run = 1'b0;
    for (int i = 0; i < 10 && ms != 0; i++) tick();
    n_checks++;
    if (bus.t_state !== 3'd0) begin
      n_fail++;
      $display("FAIL go_idle: t_state=%0d expected 0", bus.t_state);
    end
  endtask

  // Executes one instruction from IDLE back to IDLE, checking each cycle against
  // the model and returning the strobes seen in T4 and T6.
  task automatic run_instr(input logic [3:0] op, input logic c, input logic z,
                           output logic [14:0] t4_s, output logic [14:0] t6_s);
    bus.opcode = op; bus.carry_flag = c; bus.zero_flag = z; bus.run = 1'b1;
    t4_s = '0; t6_s = '0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) bus.run = 1'b0;
      if (ms == 4) t4_s = dut_s;
      if (ms == 6) t6_s = dut_s;
      n_checks++;
      if (bus.t_state !== 3'(ms) || dut_s !== model_s()) begin
        n_fail++;
        $display("FAIL instr_%0h cyc%0d: state=%0d strobes=%h expected state=%0d strobes=%h",
                 op, i, bus.t_state, dut_s, ms, model_s());
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.run = 1'b1; bus.opcode = 4'h1; bus.carry_flag = 1'b1; bus.zero_flag = 1'b1;
    ms = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.t_state !== 3'd0 || dut_s !== '0 || bus.halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: state=%0d strobes=%h halted=%b expected 0/0/0",
               bus.t_state, dut_s, bus.halted);
    end
    bus.run = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_lda();
    int          exp_st [7] = '{1, 2, 3, 4, 5, 6, 1};
    logic [14:0] exp_sb [7];
    exp_sb = '{EP | LM, CP, CE | LI, EI | LM, CE | LA, 15'h0, EP | LM};
    bus.run = 1'b1; bus.opcode = 4'h1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++;
      if (bus.t_state !== 3'(exp_st[i]) || dut_s !== exp_sb[i]) begin
        n_fail++;
        $display("FAIL lda cyc%0d: state=%0d strobes=%h expected state=%0d strobes=%h",
                 i, bus.t_state, dut_s, exp_st[i], exp_sb[i]);
      end
    end
    go_idle();
  endtask

  task automatic test_jump();
    logic [14:0] t4, t6;
    run_instr(4'h7, 1'b0, 1'b1, t4, t6);
    n_checks++;
    if (t4 !== 15'h0) begin n_fail++; $display("FAIL jc_nc_t4: got %h expected 0", t4); end
    run_instr(4'h7, 1'b1, 1'b0, t4, t6);
    n_checks++;
    if (t4 !== (EI | LP)) begin n_fail++; $display("FAIL jc_c_t4: got %h expected %h", t4, EI | LP); end
    run_instr(4'h8, 1'b0, 1'b1, t4, t6);
    n_checks++;
    if (t4 !== (EI | LP)) begin n_fail++; $display("FAIL jz_z_t4: got %h expected %h", t4, EI | LP); end
    run_instr(4'h8, 1'b1, 1'b0, t4, t6);
    n_checks++;
    if (t4 !== 15'h0) begin n_fail++; $display("FAIL jz_nz_t4: got %h expected 0", t4); end
    // Carry flips inside T4: pc_lp must follow before the next edge.
    bus.opcode = 4'h7; bus.carry_flag = 1'b1; bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    repeat (3) tick();
    #2 bus.carry_flag = 1'b0;
    #1;
    n_checks++;
    if (bus.t_state !== 3'd4 || bus.pc_lp !== 1'b0 || bus.ir_ei !== 1'b0) begin
      n_fail++;
      $display("FAIL jc_live_drop: state=%0d pc_lp=%b ir_ei=%b expected 4/0/0",
               bus.t_state, bus.pc_lp, bus.ir_ei);
    end
    bus.carry_flag = 1'b1;
    #1;
    n_checks++;
    if (bus.pc_lp !== 1'b1 || bus.ir_ei !== 1'b1) begin
      n_fail++;
      $display("FAIL jc_live_rise: pc_lp=%b ir_ei=%b expected 1/1", bus.pc_lp, bus.ir_ei);
    end
    go_idle();
  endtask

  task automatic test_alu_and_misc();
    logic [14:0] t4, t6;
    run_instr(4'h3, 1'b0, 1'b0, t4, t6);
    n_checks++;
    if (t6 !== (EU | LA | LF | SU)) begin n_fail++; $display("FAIL sub_t6: got %h expected %h", t6, EU | LA | LF | SU); end
    run_instr(4'h2, 1'b0, 1'b0, t4, t6);
    n_checks++;
    if (t6 !== (EU | LA | LF)) begin n_fail++; $display("FAIL add_t6: got %h expected %h", t6, EU | LA | LF); end
    run_instr(4'h4, 1'b0, 1'b0, t4, t6);
    run_instr(4'h5, 1'b0, 1'b0, t4, t6);
    run_instr(4'h6, 1'b0, 1'b0, t4, t6);
    run_instr(4'hE, 1'b0, 1'b0, t4, t6);
    n_checks++;
    if (t4 !== (EA | LO)) begin n_fail++; $display("FAIL out_t4: got %h expected %h", t4, EA | LO); end
    run_instr(4'h0, 1'b1, 1'b1, t4, t6);
    run_instr(4'hB, 1'b1, 1'b1, t4, t6);
    n_checks++;
    if (t4 !== 15'h0 || t6 !== 15'h0) begin
      n_fail++;
      $display("FAIL op_b_nop: t4=%h t6=%h expected 0/0", t4, t6);
    end
  endtask

  task automatic test_halt();
    bus.opcode = 4'hF; bus.run = 1'b1;
    tick();
    repeat (3) tick();
    n_checks++;
    if (bus.t_state !== 3'd4 || dut_s !== 15'h0 || bus.halted !== 1'b0) begin
      n_fail++;
      $display("FAIL hlt_t4: state=%0d strobes=%h halted=%b expected 4/0/0",
               bus.t_state, dut_s, bus.halted);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      bus.run = 1'($urandom_range(0, 1));
      n_checks++;
      if (bus.t_state !== 3'd7 || dut_s !== 15'h0 || bus.halted !== 1'b1) begin
        n_fail++;
        $display("FAIL halt_hold cyc%0d: state=%0d strobes=%h halted=%b expected 7/0/1",
                 i, bus.t_state, dut_s, bus.halted);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    ms = 0;
    n_checks++;
    if (bus.t_state !== 3'd0 || bus.halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_reset: state=%0d halted=%b expected 0/0", bus.t_state, bus.halted);
    end
    bus.run = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_run_drop();
    int exp_st [6] = '{4, 5, 6, 0, 0, 1};
    bus.opcode = 4'h2; bus.run = 1'b1;
    repeat (3) tick();
    bus.run = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) bus.run = 1'b1;
      tick();
      n_checks++;
      if (bus.t_state !== 3'(exp_st[i])) begin
        n_fail++;
        $display("FAIL run_drop cyc%0d: state=%0d expected %0d", i, bus.t_state, exp_st[i]);
      end
    end
    go_idle();
  endtask

  task automatic test_async_reset();
    bus.opcode = 4'h1; bus.run = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (bus.t_state !== 3'd5 || dut_s !== (CE | LA)) begin
      n_fail++;
      $display("FAIL pre_async_t5: state=%0d strobes=%h expected 5/%h", bus.t_state, dut_s, CE | LA);
    end
    #3 rst_n = 1'b0;
    #1;
    ms = 0;
    n_checks++;
    if (bus.t_state !== 3'd0 || dut_s !== 15'h0 || bus.halted !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: state=%0d strobes=%h halted=%b expected 0/0/0",
               bus.t_state, dut_s, bus.halted);
    end
    bus.run = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    int halt_cycles = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (ms <= 2) begin
        bus.opcode = 4'($urandom_range(0, 15));
        if (bus.opcode == 4'hF && $urandom_range(0, 7) != 0) bus.opcode = 4'h3;
      end
      bus.carry_flag = 1'($urandom_range(0, 1));
      bus.zero_flag  = 1'($urandom_range(0, 1));
      bus.run        = ($urandom_range(0, 7) != 0);
      tick();
      n_checks++;
      if (bus.t_state !== 3'(ms) || dut_s !== model_s() || bus.halted !== (ms == 7) ||
          $countones(dut_s & DRIVERS) > 1) begin
        n_fail++;
        $display("FAIL random cyc%0d: state=%0d strobes=%h halted=%b expected state=%0d strobes=%h",
                 cyc, bus.t_state, dut_s, bus.halted, ms, model_s());
      end
      if (ms == 7) halt_cycles++;
      if (halt_cycles >= 3) begin
        halt_cycles = 0;
        #2 rst_n = 1'b0;
        #1 ms = 0;
        rst_n = 1'b1;
      end
    end
    go_idle();
  endtask

  initial begin
    init_ucode();
    test_reset();
    test_lda();
    test_jump();
    test_alu_and_misc();
    test_halt();
    test_run_drop();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control sequencer for the 8-bit CPU. It steps through fixed fetch and execute T-states and drives the program counter's enable, count and load strobes, plus every other datapath control line on the shared 8-bit bus. It is the initiating end of the program-counter interface: the program counter responds to `pc_ep`/`pc_cp`/`pc_lp`, and this block decides when each is asserted. It sits between the instruction register (opcode in), the flag register (carry/zero in) and all bus participants (strobes out).

## Interface
Parameters:
- `STEPS`, 6: T-states per instruction. This is fixed; other values are unsupported.

Ports:
- `clk`  in  1  single system clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `run`  in  1  permission to start a new instruction.
- `opcode`  in  4  upper nibble of the instruction register, valid from T4 onward.
- `carry_flag`  in  1  registered carry flag.
- `zero_flag`  in  1  registered zero flag.
- `pc_ep`  out  1  program counter drives bus.
- `pc_cp`  out  1  program counter increments.
- `pc_lp`  out  1  program counter loads from bus.
- `mar_lm`  out  1  memory address register loads from bus.
- `ram_ce`  out  1  RAM drives bus.
- `ram_ri`  out  1  RAM writes from bus.
- `ir_li`  out  1  IR loads from bus.
- `ir_ei`  out  1  IR operand nibble drives bus.
- `a_la`  out  1  A loads.
- `a_ea`  out  1  A drives bus.
- `b_lb`  out  1  B loads.
- `alu_eu`  out  1  ALU drives bus.
- `alu_su`  out  1  ALU subtract select.
- `flags_lf`  out  1  flag register loads.
- `out_lo`  out  1  output register loads.
- `halted`  out  1  CPU stopped.
- `t_state`  out  3  state code: 0 = IDLE, 1–6 = T1–T6, 7 = HALT.

## Operation
- The state register is the only storage. All strobes are a combinational decode of (`t_state`, `opcode`, flags).
- In IDLE and HALT, every strobe is 0.
- Transitions:
  - IDLE→T1 when `run`=1; otherwise stay in IDLE.
  - T1→T2→T3→T4→T5→T6 unconditionally.
  - T6→T1 if `run`, else T6→IDLE.
  - T4→HALT if `opcode`=F.
  - HALT is left only by reset.
- `run` is sampled only in IDLE and T6. Deasserting it mid-instruction lets the instruction complete.
- Fetch, identical for all opcodes:
  - T1: `pc_ep`, `mar_lm`.
  - T2: `pc_cp`.
  - T3: `ram_ce`, `ir_li`.
- Execute:
  - 0 NOP: nothing.
  - 1 LDA: T4 `ir_ei`,`mar_lm`; T5 `ram_ce`,`a_la`.
  - 2 ADD: T4 `ir_ei`,`mar_lm`; T5 `ram_ce`,`b_lb`; T6 `alu_eu`,`a_la`,`flags_lf`.
  - 3 SUB: as ADD, with `alu_su` also asserted in T6.
  - 4 STA: T4 `ir_ei`,`mar_lm`; T5 `a_ea`,`ram_ri`.
  - 5 LDI: T4 `ir_ei`,`a_la`.
  - 6 JMP: T4 `ir_ei`,`pc_lp`.
  - 7 JC: T4 `ir_ei`,`pc_lp` only if `carry_flag`=1.
  - 8 JZ: T4 `ir_ei`,`pc_lp` only if `zero_flag`=1.
  - E OUT: T4 `a_ea`,`out_lo`.
  - F HLT: T4 all strobes 0, then HALT.
  - 9–D: treated as NOP.
- Bus invariant: at most one of {`pc_ep`,`ram_ce`,`ir_ei`,`a_ea`,`alu_eu`} is high in any state.
- `halted` = (`t_state`==7).

## Timing
- Reset: `t_state`=0. All outputs are 0 immediately on `rst_n` falling, independent of `clk`.
- Reset released with `run`=1: the first rising edge enters T1, so `pc_ep`/`mar_lm` are high for that cycle.
- A full instruction takes exactly 6 cycles. Back-to-back instructions have no idle gap.
- Jump flags are read combinationally during T4. A flag change in T4 changes `pc_lp` within the same cycle.
- Reset asserted mid-instruction: return to IDLE at once and abandon the partial instruction.
- HLT: the first cycle with `halted`=1 is the cycle after T4.
- `t_state` never takes a value other than 0–7. From T6 it always goes to T1 or IDLE.

## Test plan
- Reset, then `run`=1, opcode=1 (LDA) → states 1,2,3,4,5,6,1. Strobes are exactly T1 ep+lm, T2 cp, T3 ce+li, T4 ei+lm, T5 ce+la, T6 none.
- Opcode=7 with `carry_flag`=0, then repeat with `carry_flag`=1 → `pc_lp`=0 in T4, then `pc_lp`=1 and `ir_ei`=1 in T4.
- Opcode=3 (SUB) → T6 asserts `alu_eu`,`a_la`,`flags_lf`,`alu_su`. Opcode=2 (ADD) asserts the same T6 strobes with `alu_su`=0.
- Opcode=F → after T4, `t_state`=7 and `halted`=1 for 20 cycles with all strobes 0 regardless of `run`. Then `rst_n`=0 → `t_state`=0.
- `run` dropped during T3 → instruction completes through T6, then IDLE. `run` raised → T1 on the next edge.
- Assert `rst_n` low asynchronously mid-T5 (between clock edges) → all outputs 0 before the next edge. Randomized opcodes and flags for 10k cycles → bus-driver exclusivity invariant holds.
